// File: rtl/i_cache_set_assoc_if.sv
// SRAM-like instruction fetch handshake shared by the core side and the bus side.
// The cache is the slave on the core side and the master on the bus side.
interface i_cache_set_assoc_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
    modport slave  (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/i_cache_set_assoc.sv
// N-way set-associative instruction cache with multi-word lines, per-set
// round-robin replacement and an uncached bypass path. A line is refilled as a
// sequence of single-word bus reads, one outstanding at a time.
// Optional macro I_CACHE_PERF_EN adds hit/miss performance counters.
module i_cache_set_assoc #(
    parameter int WAYS         = 2,
    parameter int INDEX_WIDTH  = 7,
    parameter int OFFSET_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  except,
    input  logic                  no_cache,
    i_cache_set_assoc_if.slave    cpu,
    i_cache_set_assoc_if.master   bus
`ifdef I_CACHE_PERF_EN
    ,
    output logic [31:0]           perf_hit_cnt,
    output logic [31:0]           perf_miss_cnt
`endif
);
    localparam int SETS    = 1 << INDEX_WIDTH;
    localparam int WORDS   = 1 << (OFFSET_WIDTH - 2);
    localparam int TAG_LSB = INDEX_WIDTH + OFFSET_WIDTH;
    localparam int TAG_W   = 32 - TAG_LSB;
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CNT_W   = (OFFSET_WIDTH > 2) ? OFFSET_WIDTH - 2 : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);
    localparam logic [WAY_W-1:0] LAST_WAY  = WAY_W'(WAYS - 1);

    typedef enum logic [2:0] {S_IDLE, S_REF_REQ, S_REF_WAIT, S_UNC_REQ, S_UNC_WAIT} state_t;

    // Line storage: plain RAM arrays, contents are meaningless until valid is set
    logic [31:0]      data_mem [WAYS][SETS][WORDS];
    logic [TAG_W-1:0] tag_mem  [WAYS][SETS];

    state_t            state_q, state_d;
    logic [SETS-1:0]   valid_q [WAYS];
    logic [SETS-1:0]   valid_d [WAYS];
    logic [WAY_W-1:0]  rr_q [SETS];
    logic [WAY_W-1:0]  rr_d [SETS];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [INDEX_WIDTH-1:0] set_q, set_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic [31:0]       addr_q, addr_d;
    logic [1:0]        size_q, size_d;

    logic [TAG_W-1:0]       tag_in_s;
    logic [INDEX_WIDTH-1:0] set_in_s;
    logic [CNT_W-1:0]       word_in_s;
    logic [WAYS-1:0]        hit_way_s;
    logic [WAY_W-1:0]       hit_idx_s;
    logic [WAY_W-1:0]       victim_s;
    logic                   hit_s;
    logic                   word_done_s;
    logic                   fill_done_s;
    logic                   miss_start_s;
    logic [31:0]            refill_addr_s;
    logic                   cpu_addr_ok_s, cpu_data_ok_s;
    logic [31:0]            cpu_rdata_s;
    logic                   bus_req_s;
    logic [31:0]            bus_addr_s;
    logic [1:0]             bus_size_s;
    logic                   unused_s;

    assign tag_in_s  = cpu.addr[31:TAG_LSB];
    assign set_in_s  = cpu.addr[TAG_LSB-1:OFFSET_WIDTH];
    assign word_in_s = (OFFSET_WIDTH > 2) ? CNT_W'(cpu.addr[31:2]) : '0;
    // Refill always fetches whole words: low two address bits are zero
    assign refill_addr_s = {tag_q, set_q, {OFFSET_WIDTH{1'b0}}} | (32'(cnt_q) << 2);
    assign unused_s = ^{cpu.wr, cpu.wdata};

    // Tag compare across all ways of the addressed set; at most one way can match
    always_comb begin
        hit_way_s = '0;
        hit_idx_s = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_way_s[w] = valid_q[w][set_in_s] && (tag_mem[w][set_in_s] == tag_in_s);
            if (hit_way_s[w]) begin
                hit_idx_s = WAY_W'(w);
            end else begin
                hit_idx_s = hit_idx_s;
            end
        end
    end

    assign hit_s = (state_q == S_IDLE) && cpu.req && !no_cache && (|hit_way_s);

    // Victim choice: lowest invalid way first, otherwise the set's round-robin pointer
    always_comb begin
        victim_s = rr_q[set_in_s];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][set_in_s]) begin
                victim_s = WAY_W'(w);
            end else begin
                victim_s = victim_s;
            end
        end
    end

    // Next-state logic, core/bus handshake outputs and refill bookkeeping
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tag_d         = tag_q;
        set_d         = set_q;
        victim_d      = victim_q;
        addr_d        = addr_q;
        size_d        = size_q;
        valid_d       = valid_q;
        rr_d          = rr_q;
        word_done_s   = 1'b0;
        fill_done_s   = 1'b0;
        miss_start_s  = 1'b0;
        cpu_addr_ok_s = 1'b0;
        cpu_data_ok_s = 1'b0;
        cpu_rdata_s   = 32'h0000_0000;
        bus_req_s     = 1'b0;
        bus_addr_s    = 32'h0000_0000;
        bus_size_s    = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (hit_s) begin
                    cpu_addr_ok_s = 1'b1;
                    cpu_data_ok_s = 1'b1;
                    cpu_rdata_s   = data_mem[hit_idx_s][set_in_s][word_in_s];
                end else if (cpu.req && !except) begin
                    tag_d    = tag_in_s;
                    set_d    = set_in_s;
                    addr_d   = cpu.addr;
                    size_d   = cpu.size;
                    cnt_d    = '0;
                    victim_d = victim_s;
                    if (no_cache) begin
                        state_d = S_UNC_REQ;
                    end else begin
                        state_d      = S_REF_REQ;
                        miss_start_s = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REF_REQ: begin
                bus_req_s  = 1'b1;
                bus_addr_s = refill_addr_s;
                bus_size_s = 2'b10;
                if (bus.addr_ok && bus.data_ok) begin
                    word_done_s = 1'b1;
                end else if (bus.addr_ok) begin
                    state_d = S_REF_WAIT;
                end else begin
                    state_d = S_REF_REQ;
                end
            end
            S_REF_WAIT: begin
                if (bus.data_ok) begin
                    word_done_s = 1'b1;
                end else begin
                    state_d = S_REF_WAIT;
                end
            end
            S_UNC_REQ: begin
                bus_req_s  = 1'b1;
                bus_addr_s = addr_q;
                bus_size_s = size_q;
                if (bus.addr_ok && bus.data_ok) begin
                    cpu_addr_ok_s = 1'b1;
                    cpu_data_ok_s = 1'b1;
                    cpu_rdata_s   = bus.rdata;
                    state_d       = S_IDLE;
                end else if (bus.addr_ok) begin
                    state_d = S_UNC_WAIT;
                end else begin
                    state_d = S_UNC_REQ;
                end
            end
            S_UNC_WAIT: begin
                if (bus.data_ok) begin
                    cpu_addr_ok_s = 1'b1;
                    cpu_data_ok_s = 1'b1;
                    cpu_rdata_s   = bus.rdata;
                    state_d       = S_IDLE;
                end else begin
                    state_d = S_UNC_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A returned refill word either completes the line or requests the next word
        if (word_done_s) begin
            if (cnt_q == LAST_WORD) begin
                fill_done_s                = 1'b1;
                valid_d[victim_q][set_q]   = 1'b1;
                rr_d[set_q]                = (rr_q[set_q] == LAST_WAY) ? '0 : rr_q[set_q] + 1'b1;
                state_d                    = S_IDLE;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = S_REF_REQ;
            end
        end else begin
            fill_done_s = 1'b0;
        end
    end

    // Control state, valid bits and replacement pointers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            valid_q  <= '{default: '0};
            rr_q     <= '{default: '0};
            cnt_q    <= '0;
            tag_q    <= '0;
            set_q    <= '0;
            victim_q <= '0;
            addr_q   <= 32'h0000_0000;
            size_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            tag_q    <= tag_d;
            set_q    <= set_d;
            victim_q <= victim_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
        end
    end

    // Line data and tag writes during refill; the tag lands with the last word
    always_ff @(posedge clk) begin
        if (word_done_s) begin
            data_mem[victim_q][set_q][cnt_q] <= bus.rdata;
        end
        if (fill_done_s) begin
            tag_mem[victim_q][set_q] <= tag_q;
        end
    end

    assign cpu.addr_ok = cpu_addr_ok_s;
    assign cpu.data_ok = cpu_data_ok_s;
    assign cpu.rdata   = cpu_rdata_s;
    assign bus.req     = bus_req_s;
    assign bus.wr      = 1'b0;
    assign bus.size    = bus_size_s;
    assign bus.addr    = bus_addr_s;
    assign bus.wdata   = 32'h0000_0000;

`ifdef I_CACHE_PERF_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Counter increments: hit responses and cached misses starting a refill
    always_comb begin
        hit_cnt_d  = hit_s ? hit_cnt_q + 32'd1 : hit_cnt_q;
        miss_cnt_d = miss_start_s ? miss_cnt_q + 32'd1 : miss_cnt_q;
    end

    // Performance counter registers, wrapping naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= 32'h0000_0000;
            miss_cnt_q <= 32'h0000_0000;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign perf_hit_cnt  = hit_cnt_q;
    assign perf_miss_cnt = miss_cnt_q;
`endif
endmodule
